// File: rtl/mem_if_pkg.sv
// Shared types and width helpers for the data_memory request-side initiator.
package mem_if_pkg;

  localparam int unsigned MEM_RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STORE    = 3'd1,
    LD_ISSUE = 3'd2,
    LD_WAIT  = 3'd3,
    LD_RESP  = 3'd4
  } state_e;

  function automatic int unsigned addr_width(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int unsigned len_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // A zero length means one word; anything above the burst limit is cut to the limit.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_burst);
    if (len == 0) return 1;
    if (len > max_burst) return max_burst;
    return len;
  endfunction

endpackage

// File: rtl/burst_addr_counter.sv
// Tracks the current word address and remaining word count of a load burst.
module burst_addr_counter
  import mem_if_pkg::*;
#(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned ADDR_W    = addr_width(SIZE),
  parameter int unsigned LEN_W     = len_width(MAX_BURST)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  output logic [ADDR_W-1:0] next_addr_c,
  output logic              last_c
);

  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [LEN_W-1:0]  remaining_q, remaining_d;

  // Explicit compare so the wrap is correct for non-power-of-2 sizes.
  always_comb begin
    addr_inc    = (addr_q == ADDR_W'(SIZE - 1)) ? '0 : addr_q + ADDR_W'(1);
    addr_d      = addr_q;
    remaining_d = remaining_q;
    if (load) begin
      addr_d      = start_addr;
      remaining_d = LEN_W'(clamp_len(32'(start_len), MAX_BURST));
    end else if (step) begin
      addr_d      = addr_inc;
      remaining_d = remaining_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign next_addr_c = addr_d;
  assign last_c      = (remaining_q == LEN_W'(1));

endmodule

// File: rtl/data_memory_initiator.sv
// Request-side master for data_memory: single-word stores and 1..MAX_BURST word load bursts
// returned on a valid/ready response stream.
module data_memory_initiator
  import mem_if_pkg::*;
#(
  parameter  int unsigned WORDSIZE  = 64,
  parameter  int unsigned SIZE      = 32,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned ADDR_W    = addr_width(SIZE),
  localparam int unsigned LEN_W     = len_width(MAX_BURST)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WORDSIZE-1:0] resp_data,
  output logic                resp_last,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_write_enable,
  output logic                mem_read,
  output logic [WORDSIZE-1:0] mem_data_input,
  input  logic [WORDSIZE-1:0] mem_data_output
);

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_last_q, resp_last_d;
  logic [WORDSIZE-1:0] resp_data_q, resp_data_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_rd_q, mem_rd_d;
  logic [WORDSIZE-1:0] mem_din_q, mem_din_d;
  logic                cnt_load, cnt_step, cnt_last;
  logic [ADDR_W-1:0]   cnt_next_addr;

  burst_addr_counter #(
    .SIZE      (SIZE),
    .MAX_BURST (MAX_BURST),
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W)
  ) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .load        (cnt_load),
    .step        (cnt_step),
    .start_addr  (req_addr),
    .start_len   (req_len),
    .next_addr_c (cnt_next_addr),
    .last_c      (cnt_last)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    mem_we_d     = 1'b0;
    mem_rd_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    resp_valid_d = 1'b0;
    resp_last_d  = 1'b0;
    resp_data_d  = resp_data_q;
    cnt_load     = 1'b0;
    cnt_step     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          mem_addr_d = req_addr;
          if (req_write) begin
            state_d   = STORE;
            mem_we_d  = 1'b1;
            mem_din_d = req_wdata;
          end else begin
            state_d  = LD_ISSUE;
            mem_rd_d = 1'b1;
            cnt_load = 1'b1;
          end
        end
      end
      STORE:    state_d = IDLE;
      LD_ISSUE: state_d = LD_WAIT;
      LD_WAIT: begin
        state_d      = LD_RESP;
        resp_data_d  = mem_data_output;
        resp_valid_d = 1'b1;
        resp_last_d  = cnt_last;
      end
      LD_RESP: begin
        resp_valid_d = 1'b1;
        resp_last_d  = resp_last_q;
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_last_d  = 1'b0;
          cnt_step     = 1'b1;
          if (cnt_last) begin
            state_d = IDLE;
          end else begin
            state_d    = LD_ISSUE;
            mem_rd_d   = 1'b1;
            mem_addr_d = cnt_next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_din_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_data_q  <= resp_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_rd_q     <= mem_rd_d;
      mem_din_q    <= mem_din_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign busy             = busy_q;
  assign resp_valid       = resp_valid_q;
  assign resp_last        = resp_last_q;
  assign resp_data        = resp_data_q;
  assign mem_addr         = mem_addr_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read         = mem_rd_q;
  assign mem_data_input   = mem_din_q;

endmodule
